bus8_cmd_master: RTL and testbench
==================================

# bus8_cmd_master

Bus8 initiator that turns a byte-stream command channel (typically a UART RX) into single-cycle Bus8 read/write strobes, and returns read data as a response byte stream (typically into a UART TX). It drives the CS/Wr_Rd_n/address/write-data side of the 8-bit register bus and consumes the read-data-valid return from any Bus8 register bank. It sits between the host link and the register banks.

## Interface
Parameters:
- ADDR_WIDTH, 4: bus address width, 1..7; the address is taken from opcode bits [ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 16: cycles to wait for i_Bus_Rd_DV after a read strobe; must be >= 1.
- TIMEOUT_BYTE, 8'hEE: response byte returned on read timeout.

Ports:
- i_Bus_Clk  in  1  clock; all logic on the rising edge.
- i_Bus_Rst  in  1  reset; synchronous, active-high.
- i_Cmd_DV  in  1  command byte valid, one-cycle pulse per byte.
- i_Cmd_Byte  in  8  command byte.
- o_Busy  out  1  high while a read is outstanding; bytes arriving then are dropped.
- o_Cmd_Drop  out  1  one-cycle pulse when a command byte is discarded.
- o_Bus_CS  out  1  bus strobe, high for exactly one cycle per transaction.
- o_Bus_Wr_Rd_n  out  1  1 = write, 0 = read; valid while o_Bus_CS is high.
- o_Bus_Addr8  out  ADDR_WIDTH  bus address.
- o_Bus_Wr_Data  out  8  write data.
- i_Bus_Rd_Data  in  8  read data from the bank.
- i_Bus_Rd_DV  in  1  read data valid from the bank.
- o_Resp_DV  out  1  one-cycle pulse per response byte.
- o_Resp_Byte  out  8  response byte; held until the next response.
- o_Timeout  out  1  one-cycle pulse coincident with a timeout response.

## Operation
- Command format: byte 0 is the opcode. Bit 7 selects write (1) or read (0), and bits [ADDR_WIDTH-1:0] are the address. The remaining opcode bits are ignored. A write carries a byte 1, which is the data byte, with all 8 bits taken as data.
- State machine:
  - IDLE: on i_Cmd_DV with bit7=1, latch the address and go to GET_DATA. On i_Cmd_DV with bit7=0, latch the address, issue the read strobe, clear the timeout counter and go to READ_WAIT.
  - GET_DATA: on i_Cmd_DV, latch the data byte, issue the write strobe and go to IDLE. There is no timeout in this state.
  - READ_WAIT: o_Busy=1.
    - On i_Bus_Rd_DV: o_Resp_Byte<=i_Bus_Rd_Data, pulse o_Resp_DV, go to IDLE.
    - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 and there is no DV: o_Resp_Byte<=TIMEOUT_BYTE, pulse o_Resp_DV and o_Timeout, go to IDLE.
- Strobe: o_Bus_CS is registered and high for exactly one cycle. o_Bus_Wr_Rd_n, o_Bus_Addr8 and o_Bus_Wr_Data are registered with it and hold their values afterwards.
- Writes produce no response byte.
- Boundary cases:
  - i_Cmd_DV in READ_WAIT: the byte is discarded and o_Cmd_Drop pulses the next cycle. The FSM is unaffected.
  - i_Bus_Rd_DV in the same cycle as the timeout condition: DV wins. The response carries the data and o_Timeout stays 0.
  - i_Bus_Rd_DV outside READ_WAIT (stray or late): ignored, with no response.
  - Reset mid-read: the transaction is abandoned, no response is sent, and the FSM returns to IDLE.
  - Reset mid-write (in GET_DATA): the opcode is discarded.

## Timing
- Reset values: o_Bus_CS=0, o_Bus_Wr_Rd_n=0, o_Bus_Addr8=0, o_Bus_Wr_Data=0, o_Resp_DV=0, o_Resp_Byte=0, o_Timeout=0, o_Busy=0, o_Cmd_Drop=0; state IDLE; counter 0.
- Write: data-byte DV in cycle N produces CS=1 with Wr_Rd_n=1 in cycle N+1.
- Read: opcode DV in cycle N produces CS=1 with Wr_Rd_n=0 in cycle N+1, and o_Busy=1 from cycle N+1.
  - The FSM accepts i_Bus_Rd_DV in cycles N+1 through N+TIMEOUT_CYCLES.
  - Rd_DV in cycle M produces o_Resp_DV in cycle M+1, and o_Busy falls in cycle M+1.
  - With no DV, the timeout response appears in cycle N+TIMEOUT_CYCLES+1.
- Against a registered bank that asserts Rd_DV one cycle after CS, opcode-to-response latency is 3 cycles.
- A new opcode is accepted in the same cycle the response pulses (state is IDLE).
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.

## Test plan
- Write: opcode 8'h83 at cycle 0, data 8'h5A at cycle 3 -> CS=1, Wr_Rd_n=1, Addr=3, Wr_Data=8'h5A at cycle 4 only. No o_Resp_DV.
- Read with a bank modelled as "DV 1 cycle after CS": opcode 8'h03 at cycle 0, bank data 8'hC3 -> CS/read at cycle 1, Rd_DV at 2, o_Resp_DV=1 with byte 8'hC3 at 3, o_Busy high in cycles 1–2.
- Timeout with TIMEOUT_CYCLES=8: read opcode at cycle 0, no DV -> o_Resp_DV and o_Timeout at cycle 9, byte 8'hEE, o_Busy low at 9.
- DV exactly at cycle 8 (the last window cycle) with data 8'h11 -> response 8'h11 at cycle 9, o_Timeout=0. DV at cycle 9 -> ignored, and the timeout response is sent.
- Byte 8'h05 during READ_WAIT -> o_Cmd_Drop pulse, no new CS. Stray Rd_DV in IDLE -> no response.
- Reset asserted one cycle after a read CS, with DV arriving after reset release -> no o_Resp_DV and all outputs at reset values. A following write 8'h81/8'h22 completes normally.

Source files
------------

// File: rtl/bus8_cmd_master.sv
// Bus8 initiator: decodes a byte-stream command channel into single-cycle bus
// strobes and returns read data (or a timeout marker) as a response byte.
module bus8_cmd_master #(
  parameter int          ADDR_WIDTH     = 4,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  TIMEOUT_BYTE   = 8'hEE
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst,
  input  logic                  i_Cmd_DV,
  input  logic [7:0]            i_Cmd_Byte,
  output logic                  o_Busy,
  output logic                  o_Cmd_Drop,
  output logic                  o_Bus_CS,
  output logic                  o_Bus_Wr_Rd_n,
  output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
  output logic [7:0]            o_Bus_Wr_Data,
  input  logic [7:0]            i_Bus_Rd_Data,
  input  logic                  i_Bus_Rd_DV,
  output logic                  o_Resp_DV,
  output logic [7:0]            o_Resp_Byte,
  output logic                  o_Timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GET_DATA  = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;

  logic [1:0]            r_State;
  logic [CW-1:0]         r_Cnt;
  logic [ADDR_WIDTH-1:0] r_Addr;
  logic                  r_CS, r_Wr_Rd_n, r_Resp_DV, r_Timeout, r_Cmd_Drop;
  logic [ADDR_WIDTH-1:0] r_Bus_Addr;
  logic [7:0]            r_Wr_Data, r_Resp_Byte;
  logic [ADDR_WIDTH-1:0] w_Op_Addr;

  assign w_Op_Addr = i_Cmd_Byte[ADDR_WIDTH-1:0];

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      r_State     <= IDLE;
      r_Cnt       <= '0;
      r_Addr      <= '0;
      r_CS        <= 1'b0;
      r_Wr_Rd_n   <= 1'b0;
      r_Bus_Addr  <= '0;
      r_Wr_Data   <= 8'h00;
      r_Resp_DV   <= 1'b0;
      r_Resp_Byte <= 8'h00;
      r_Timeout   <= 1'b0;
      r_Cmd_Drop  <= 1'b0;
    end else begin
      r_CS       <= 1'b0;
      r_Resp_DV  <= 1'b0;
      r_Timeout  <= 1'b0;
      r_Cmd_Drop <= 1'b0;
      case (r_State)
        IDLE: if (i_Cmd_DV) begin
          r_Addr <= w_Op_Addr;
          if (i_Cmd_Byte[7]) begin
            r_State <= GET_DATA;
          end else begin
            r_CS       <= 1'b1;
            r_Wr_Rd_n  <= 1'b0;
            r_Bus_Addr <= w_Op_Addr;
            r_Cnt      <= '0;
            r_State    <= READ_WAIT;
          end
        end
        GET_DATA: if (i_Cmd_DV) begin
          r_CS       <= 1'b1;
          r_Wr_Rd_n  <= 1'b1;
          r_Bus_Addr <= r_Addr;
          r_Wr_Data  <= i_Cmd_Byte;
          r_State    <= IDLE;
        end
        READ_WAIT: begin
          r_Cmd_Drop <= i_Cmd_DV;
          // Returned data beats the timeout when both land in the last window cycle
          if (i_Bus_Rd_DV) begin
            r_Resp_Byte <= i_Bus_Rd_Data;
            r_Resp_DV   <= 1'b1;
            r_State     <= IDLE;
          end else if (r_Cnt == LAST) begin
            r_Resp_Byte <= TIMEOUT_BYTE;
            r_Resp_DV   <= 1'b1;
            r_Timeout   <= 1'b1;
            r_State     <= IDLE;
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign o_Busy        = (r_State == READ_WAIT);
  assign o_Cmd_Drop    = r_Cmd_Drop;
  assign o_Bus_CS      = r_CS;
  assign o_Bus_Wr_Rd_n = r_Wr_Rd_n;
  assign o_Bus_Addr8   = r_Bus_Addr;
  assign o_Bus_Wr_Data = r_Wr_Data;
  assign o_Resp_DV     = r_Resp_DV;
  assign o_Resp_Byte   = r_Resp_Byte;
  assign o_Timeout     = r_Timeout;

endmodule

// File: tb/tb_bus8_cmd_master.sv
// Scoreboard bench for bus8_cmd_master: directed commands push expected
// strobes/responses/drops; a negedge monitor pops and compares them.
module tb_bus8_cmd_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_dv, rd_dv;
  logic [7:0] cmd_byte, rd_data;
  logic       busy, drop, cs, wr_rd_n, resp_dv, tmo;
  logic [3:0] addr;
  logic [7:0] wr_data, resp_byte;

  bus8_cmd_master #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(8), .TIMEOUT_BYTE(8'hEE)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Cmd_DV(cmd_dv), .i_Cmd_Byte(cmd_byte),
    .o_Busy(busy), .o_Cmd_Drop(drop), .o_Bus_CS(cs), .o_Bus_Wr_Rd_n(wr_rd_n),
    .o_Bus_Addr8(addr), .o_Bus_Wr_Data(wr_data), .i_Bus_Rd_Data(rd_data),
    .i_Bus_Rd_DV(rd_dv), .o_Resp_DV(resp_dv), .o_Resp_Byte(resp_byte), .o_Timeout(tmo));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [15:0] v; } exp_t;
  exp_t q_cs[$], q_rsp[$], q_drp[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int gc, input int ec, input logic [15:0] g, input logic [15:0] e);
    checks++;
    if (gc != ec || g !== e) begin
      errors++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", nm, g, gc, e, ec);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, g, e, cyc);
    end
  endtask

  task automatic exp_cs(input int c, input logic w, input logic [3:0] a, input logic [7:0] d);
    exp_t e; e.c = c; e.v = {3'b0, w, a, d}; q_cs.push_back(e);
  endtask
  task automatic exp_rsp(input int c, input logic t, input logic [7:0] b);
    exp_t e; e.c = c; e.v = {7'b0, t, b}; q_rsp.push_back(e);
  endtask
  task automatic exp_drp(input int c);
    exp_t e; e.c = c; e.v = 16'h0001; q_drp.push_back(e);
  endtask

  // Monitor: every DUT event must match the head of its queue, in value and cycle
  always @(negedge clk) begin
    exp_t e;
    if (cs) begin
      if (q_cs.size() == 0) chk("cs_unexpected", cyc, -1, {3'b0, wr_rd_n, addr, wr_data}, 16'h0);
      else begin e = q_cs.pop_front(); chk("cs", cyc, e.c, {3'b0, wr_rd_n, addr, wr_data}, e.v); end
    end
    if (resp_dv) begin
      if (q_rsp.size() == 0) chk("resp_unexpected", cyc, -1, {7'b0, tmo, resp_byte}, 16'h0);
      else begin e = q_rsp.pop_front(); chk("resp", cyc, e.c, {7'b0, tmo, resp_byte}, e.v); end
    end else if (tmo) chk("timeout_without_resp", cyc, -1, 16'h1, 16'h0);
    if (drop) begin
      if (q_drp.size() == 0) chk("drop_unexpected", cyc, -1, 16'h1, 16'h0);
      else begin e = q_drp.pop_front(); chk("drop", cyc, e.c, 16'h1, e.v); end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic cmd(input logic [7:0] b);
    cmd_dv = 1'b1; cmd_byte = b; tick(); cmd_dv = 1'b0;
  endtask
  task automatic rd(input logic [7:0] d);
    rd_dv = 1'b1; rd_data = d; tick(); rd_dv = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {6'b0, cs, wr_rd_n, addr, wr_data, resp_dv, resp_byte, tmo, busy, drop};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int b;
    rst = 1'b1; cmd_dv = 1'b0; rd_dv = 1'b0; cmd_byte = 8'h00; rd_data = 8'h00;
    repeat (3) tick();
    chkv("reset_outputs", outs(), 32'h0);
    rst = 1'b0;
    tick();

    // Write 0x83 / 0x5A with a gap between opcode and data
    b = cyc;
    exp_cs(b + 4, 1'b1, 4'h3, 8'h5A);
    cmd(8'h83); tick(); tick(); cmd(8'h5A);
    repeat (3) tick();

    // Read, bank answers one cycle after CS
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'h3, 8'h5A);
    exp_rsp(b + 3, 1'b0, 8'hC3);
    cmd(8'h03);
    chkv("busy_read_c1", {31'b0, busy}, 32'h1);
    tick();
    chkv("busy_read_c2", {31'b0, busy}, 32'h1);
    rd(8'hC3);
    chkv("busy_read_c3", {31'b0, busy}, 32'h0);
    repeat (2) tick();

    // Timeout, then a write opcode accepted in the response cycle
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'h7, 8'h5A);
    exp_rsp(b + 9, 1'b1, 8'hEE);
    exp_cs(b + 11, 1'b1, 4'hC, 8'h33);
    cmd(8'h07);
    repeat (7) tick();
    chkv("busy_timeout_c8", {31'b0, busy}, 32'h1);
    tick();
    chkv("busy_timeout_c9", {31'b0, busy}, 32'h0);
    cmd(8'h8C); cmd(8'h33);
    repeat (3) tick();

    // Data in the last window cycle wins over timeout
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'hA, 8'h33);
    exp_rsp(b + 9, 1'b0, 8'h11);
    cmd(8'h0A);
    repeat (7) tick();
    rd(8'h11);
    repeat (3) tick();

    // Data one cycle too late: timeout sent, late data ignored
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'hB, 8'h33);
    exp_rsp(b + 9, 1'b1, 8'hEE);
    cmd(8'h0B);
    repeat (8) tick();
    rd(8'h66);
    repeat (3) tick();

    // Byte during a read is dropped; stray DV in IDLE produces nothing
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'h2, 8'h33);
    exp_drp(b + 3);
    exp_rsp(b + 5, 1'b0, 8'h77);
    cmd(8'h02); tick(); cmd(8'h05); tick(); rd(8'h77);
    repeat (2) tick();
    rd(8'h99);
    repeat (3) tick();

    // Reset one cycle after a read strobe abandons the read
    b = cyc;
    exp_cs(b + 1, 1'b0, 4'h4, 8'h33);
    cmd(8'h04); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chkv("reset_mid_read", outs(), 32'h0);
    rd(8'h55);
    repeat (3) tick();
    b = cyc;
    exp_cs(b + 2, 1'b1, 4'h1, 8'h22);
    cmd(8'h81); cmd(8'h22);
    repeat (4) tick();

    chkv("cs_queue_drained", q_cs.size(), 32'd0);
    chkv("resp_queue_drained", q_rsp.size(), 32'd0);
    chkv("drop_queue_drained", q_drp.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
